// File: rtl/data_sram_ctrl.sv
// Load/store sequencer between the EX/MEM pipeline and an SRAM-like data bus.
// It tracks outstanding requests, buffers responses in order, and discards results after a flush.
module data_sram_ctrl #(
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    input  logic        resp_ready,
    input  logic        flush,
    output logic        busy,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [2:0] MAX_C     = 3'(MAX_OUT);
    localparam logic [1:0] LAST_PTR  = 2'(MAX_OUT - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  out_cnt_q, out_cnt_d;
    logic [2:0]  discard_cnt_q, discard_cnt_d;
    logic [2:0]  fifo_cnt_q, fifo_cnt_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0] mem_q [4];

    logic        issue_s;
    logic        dok_s;
    logic        push_s;
    logic        pop_s;
    logic [3:0]  room_sum_s;

    function automatic logic [3:0] calc_wstrb(input logic we, input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        if (!we) begin
            strb = 4'b0000;
        end else begin
            case (size)
                2'd0:    strb = 4'b0001 << addr_lo;
                2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
                default: strb = 4'b1111;
            endcase
        end
        return strb;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Counting buffered responses as occupied guarantees every data_ok finds a free slot.
    assign room_sum_s = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
    assign issue_s    = resetn & req_valid & ~flush & (state_q != ST_DRAIN)
                      & (out_cnt_q < MAX_C) & (room_sum_s < {1'b0, MAX_C});
    assign dok_s      = data_sram_data_ok & (out_cnt_q != 3'd0);
    assign push_s     = dok_s & ~flush & (discard_cnt_q == 3'd0);
    assign pop_s      = (fifo_cnt_q != 3'd0) & resp_ready & ~flush;

    assign data_sram_req   = issue_s;
    assign req_ready       = issue_s & data_sram_addr_ok;
    assign data_sram_wr    = req_we;
    assign data_sram_size  = req_size;
    assign data_sram_addr  = req_addr;
    assign data_sram_wdata = req_wdata;
    assign data_sram_wstrb = calc_wstrb(req_we, req_size, req_addr[1:0]);

    assign resp_valid = (fifo_cnt_q != 3'd0);
    assign resp_rdata = mem_q[rd_ptr_q];
    assign busy       = (out_cnt_q != 3'd0);

    // Outstanding and discard counters; a flush recomputes the discard count from scratch.
    always_comb begin
        out_cnt_d = out_cnt_q + {2'b00, req_ready} - {2'b00, dok_s};
        if (flush) begin
            discard_cnt_d = out_cnt_q - {2'b00, dok_s};
        end else if (dok_s && (discard_cnt_q != 3'd0)) begin
            discard_cnt_d = discard_cnt_q - 3'd1;
        end else begin
            discard_cnt_d = discard_cnt_q;
        end
    end

    // Response FIFO pointer and occupancy update.
    always_comb begin
        if (flush) begin
            fifo_cnt_d = 3'd0;
            rd_ptr_d   = 2'd0;
            wr_ptr_d   = 2'd0;
        end else begin
            fifo_cnt_d = fifo_cnt_q + {2'b00, push_s} - {2'b00, pop_s};
            rd_ptr_d   = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        end
    end

    // Control FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            if (out_cnt_d != 3'd0) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_ready) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (out_cnt_d == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_DRAIN: begin
                    if (discard_cnt_d == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            out_cnt_q     <= 3'd0;
            discard_cnt_q <= 3'd0;
            fifo_cnt_q    <= 3'd0;
            rd_ptr_q      <= 2'd0;
            wr_ptr_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Response FIFO storage; only the first MAX_OUT entries are ever addressed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= data_sram_rdata;
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_data_sram_ctrl;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_we, req_ready, resp_valid, resp_ready, flush, busy;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_sram_ctrl #(.MAX_OUT(MAXO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ready(resp_ready),
        .flush(flush), .busy(busy),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'h0;
        resp_ready = 1'b0; flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
    endtask

    task automatic issue_load(input logic [31:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = a; data_sram_addr_ok = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        settle();
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", data_sram_req); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_load();
        issue_load(32'h0000_1000);
        settle();
        tests++; if (data_sram_req !== 1'b1) begin fails++; $display("FAIL ld_req got %b want 1", data_sram_req); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ld_req_ready got %b want 1", req_ready); end
        tests++; if (data_sram_wstrb !== 4'b0000) begin fails++; $display("FAIL ld_wstrb got %b want 0000", data_sram_wstrb); end
        tick();
        idle_inputs();
        settle();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ld_busy got %b want 1", busy); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL ld_rr_once got %b want 0", req_ready); end
        tick();
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        settle();
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL ld_no_bypass got %b want 0", resp_valid); end
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL ld_resp_valid got %b want 1", resp_valid); end
        tests++; if (resp_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ld_rdata got %h want deadbeef", resp_rdata); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ld_busy_end got %b want 0", busy); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        settle();
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL ld_popped got %b want 0", resp_valid); end
    endtask

    task automatic test_stores();
        int n = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h0000_1003;
        req_wdata = 32'h4444_4444; data_sram_addr_ok = 1'b1;
        settle();
        tests++; if (data_sram_wstrb !== 4'b1000) begin fails++; $display("FAIL st_b_wstrb got %b want 1000", data_sram_wstrb); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL st_b_rr got %b want 1", req_ready); end
        tick();
        req_size = 2'd1; req_addr = 32'h0000_1002;
        settle();
        tests++; if (data_sram_wstrb !== 4'b1100) begin fails++; $display("FAIL st_h_wstrb got %b want 1100", data_sram_wstrb); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL st_h_rr got %b want 1", req_ready); end
        tick();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        tick();
        tick();
        data_sram_data_ok = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (resp_valid === 1'b1) n++;
            tick();
        end
        resp_ready = 1'b0;
        tests++; if (n !== 2) begin fails++; $display("FAIL st_resp_count got %0d want 2", n); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL st_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        issue_load(32'h0000_2000);
        settle();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_rr_a got %b want 1", req_ready); end
        tick();
        req_addr = 32'h0000_2004;
        settle();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_rr_b got %b want 1", req_ready); end
        tick();
        req_addr = 32'h0000_2008;
        for (int i = 0; i < 3; i++) begin
            settle();
            tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL b2b_hold_out got %b want 0", data_sram_req); end
            tick();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0001;
        tick();
        data_sram_rdata = 32'hAAAA_0002;
        settle();
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL b2b_hold_mix got %b want 0", data_sram_req); end
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL b2b_hold_fifo got %b want 0", data_sram_req); end
        tests++; if (resp_rdata !== 32'hAAAA_0001) begin fails++; $display("FAIL b2b_head_a got %h want aaaa0001", resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        settle();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_rr_c got %b want 1", req_ready); end
        tests++; if (resp_rdata !== 32'hAAAA_0002) begin fails++; $display("FAIL b2b_head_b got %h want aaaa0002", resp_rdata); end
        tick();
        idle_inputs();
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0003;
        tick();
        data_sram_data_ok = 1'b0;
        resp_ready = 1'b1;
        settle();
        tests++; if (resp_rdata !== 32'hAAAA_0002) begin fails++; $display("FAIL b2b_order_b got %h want aaaa0002", resp_rdata); end
        tick();
        settle();
        tests++; if (resp_rdata !== 32'hAAAA_0003) begin fails++; $display("FAIL b2b_order_c got %h want aaaa0003", resp_rdata); end
        tick();
        resp_ready = 1'b0;
        settle();
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b want 0", resp_valid); end
        tick();
    endtask

    task automatic test_flush();
        issue_load(32'h0000_3000);
        tick();
        req_addr = 32'h0000_3004;
        tick();
        req_addr = 32'h0000_3008; flush = 1'b1;
        settle();
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL fl_req_on_flush got %b want 0", data_sram_req); end
        tick();
        flush = 1'b0; data_sram_addr_ok = 1'b0;
        settle();
        tests++; if (dut.discard_cnt_q !== 3'd2) begin fails++; $display("FAIL fl_discard got %0d want 2", dut.discard_cnt_q); end
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL fl_drain_block got %b want 0", data_sram_req); end
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_0001;
        tick();
        data_sram_rdata = 32'hBAD0_0002;
        settle();
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL fl_drain_block2 got %b want 0", data_sram_req); end
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL fl_no_resp got %b want 0", resp_valid); end
        tests++; if (data_sram_req !== 1'b1) begin fails++; $display("FAIL fl_idle_req got %b want 1", data_sram_req); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_dataok();
        issue_load(32'h0000_4000);
        tick();
        req_addr = 32'h0000_4004;
        tick();
        idle_inputs();
        flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        tick();
        flush = 1'b0; data_sram_data_ok = 1'b0;
        settle();
        tests++; if (dut.discard_cnt_q !== 3'd1) begin fails++; $display("FAIL fd_discard got %0d want 1", dut.discard_cnt_q); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL fd_dropped got %b want 0", resp_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL fd_busy got %b want 1", busy); end
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL fd_second_dropped got %b want 0", resp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fd_busy_end got %b want 0", busy); end
        tick();
    endtask

    task automatic test_async_reset();
        issue_load(32'h0000_5000);
        tick();
        req_addr = 32'h0000_5004;
        tick();
        idle_inputs();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
        tick();
        data_sram_data_ok = 1'b0;
        req_valid = 1'b1;
        settle();
        tests++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL ar_pre got rv=%b busy=%b want 1 1", resp_valid, busy); end
        resetn = 1'b0;
        #1;
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL ar_req got %b want 0", data_sram_req); end
        tests++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL ar_resp got %b %h want 0 0", resp_valid, resp_rdata); end
        tests++; if (busy !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL ar_busy_rr got %b %b want 0 0", busy, req_ready); end
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        issue_load(32'h0000_6000);
        settle();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ar_new_rr got %b want 1", req_ready); end
        tick();
        idle_inputs();
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h600D_CAFE;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h600D_CAFE) begin fails++; $display("FAIL ar_new_resp got %b %h want 1 600dcafe", resp_valid, resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] bus_q[$];
        int out_m = 0;
        int disc_m = 0;
        logic hold = 1'b0;
        logic exp_req, hs, dok;
        logic [3:0] exp_strb;
        int nb, off;
        idle_inputs();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!hold) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_we    = $urandom_range(0, 1) == 1;
                req_size  = 2'($urandom_range(0, 2));
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            data_sram_addr_ok = ($urandom_range(0, 2) != 0);
            data_sram_data_ok = (bus_q.size() > 0) && ($urandom_range(0, 1) == 1);
            data_sram_rdata   = data_sram_data_ok ? bus_q[0] : $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            resp_ready = $urandom_range(0, 1) == 1;
            settle();
            exp_req = req_valid && !flush && disc_m == 0 && out_m < MAXO && (exp_q.size() + out_m) < MAXO;
            nb  = 1 << req_size;
            off = int'(req_addr[1:0]) & ~(nb - 1) & 3;
            exp_strb = req_we ? 4'(((1 << nb) - 1) << off) : 4'b0000;
            tests++; if (data_sram_req !== exp_req) begin fails++; $display("FAIL rnd_req cyc %0d got %b want %b", cyc, data_sram_req, exp_req); end
            tests++; if (req_ready !== (exp_req && data_sram_addr_ok)) begin fails++; $display("FAIL rnd_rr cyc %0d got %b want %b", cyc, req_ready, exp_req && data_sram_addr_ok); end
            tests++; if (data_sram_wstrb !== exp_strb) begin fails++; $display("FAIL rnd_wstrb cyc %0d got %b want %b", cyc, data_sram_wstrb, exp_strb); end
            tests++; if (data_sram_addr !== req_addr || data_sram_wr !== req_we) begin fails++; $display("FAIL rnd_pass cyc %0d got %h %b want %h %b", cyc, data_sram_addr, data_sram_wr, req_addr, req_we); end
            tests++; if (resp_valid !== (exp_q.size() > 0)) begin fails++; $display("FAIL rnd_rv cyc %0d got %b want %b", cyc, resp_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                tests++; if (resp_rdata !== exp_q[0]) begin fails++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc, resp_rdata, exp_q[0]); end
            end
            tests++; if (busy !== (out_m != 0)) begin fails++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, out_m != 0); end
            hs  = exp_req && data_sram_addr_ok;
            dok = data_sram_data_ok;
            if (flush) begin
                exp_q.delete();
                out_m  = out_m - int'(dok);
                disc_m = out_m;
            end else begin
                if (resp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (dok) begin
                    if (disc_m > 0) disc_m--;
                    else exp_q.push_back(data_sram_rdata);
                end
                out_m = out_m + int'(hs) - int'(dok);
            end
            if (dok) void'(bus_q.pop_front());
            if (hs) bus_q.push_back($urandom);
            hold = req_valid && !hs;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        tick();
        test_stores();
        test_back_to_back();
        test_flush();
        test_flush_dataok();
        test_async_reset();
        tick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
